if_stage: RTL and testbench
===========================

Name: if_stage

Overview:
- Instruction-fetch stage directly upstream of the decode stage.
- Generates the fetch PC and runs a single-outstanding req/gnt/rvalid handshake to instruction memory.
- Buffers fetched {pc, inst} pairs in a small FIFO and presents them to decode, honouring decode's stall and a redirect from EX.

Parameters:
- XLEN, 64, PC/address width
- RESET_PC, 64'h0000_0000_8000_0000, first fetch address after reset
- FIFO_DEPTH, 2, fetch buffer entries; power of two, minimum 2

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- stall_i  in  1  decode cannot accept the head instruction this cycle
- redirect_i  in  1  branch/jump taken; flush and refetch
- redirect_pc_i  in  XLEN  new fetch PC, sampled when redirect_i=1
- imem_req_o  out  1  fetch request valid
- imem_addr_o  out  XLEN  fetch address, stable while imem_req_o=1 and not granted
- imem_gnt_i  in  1  request accepted this cycle
- imem_rvalid_i  in  1  read data valid; earliest the cycle after the grant
- imem_rdata_i  in  32  instruction word
- inst_valid_o  out  1  inst_o/pc_o hold a valid instruction
- inst_o  out  32  instruction to decode
- pc_o  out  XLEN  PC of inst_o

Behaviour:
- Reset values:
  - fetch_pc=RESET_PC; FSM=REQ; FIFO empty; no outstanding request
  - imem_req_o=0 during the reset cycle; imem_addr_o=RESET_PC
  - inst_valid_o=0, inst_o=32'h0000_0013 (NOP), pc_o=0
- FSM states:
  - REQ: issue a request when space is available
  - WAIT: one request outstanding
  - DROP: one stale request outstanding; its response is discarded
- Space condition: fifo_count + outstanding < FIFO_DEPTH.
- imem_req_o = (state==REQ) & space & !redirect_i & !rst. imem_addr_o=fetch_pc.
- REQ to WAIT on imem_gnt_i & imem_req_o; fetch_pc += 4 at the same edge. Wrap modulo 2^XLEN.
- WAIT to REQ on imem_rvalid_i; {fetch-time pc, imem_rdata_i} is pushed into the FIFO. The pc is latched at grant.
- Sustained throughput is 1 instruction per 2 cycles minimum. No request is issued in the rvalid cycle.
- Output side:
  - inst_valid_o = FIFO non-empty; inst_o/pc_o = head entry, driven directly from registers.
  - When empty, inst_o = NOP and pc_o holds its last value.
  - The head pops when inst_valid_o & !stall_i.
  - Push and pop in the same cycle are allowed while full; count is unchanged.
- Redirect (highest priority):
  - At the next edge: FIFO cleared, fetch_pc <= redirect_pc_i, any pop or push in that cycle ignored.
  - State WAIT and no rvalid this cycle: go to DROP.
  - State WAIT and rvalid in the same cycle: data discarded, go to REQ.
  - State DROP: stay in DROP until the stale rvalid arrives.
- DROP to REQ on imem_rvalid_i; the data is discarded. inst_valid_o stays 0.
- imem_rvalid_i in REQ (e.g. a response left over from before reset) is ignored.
- Reset mid-operation: all state returns to reset values at the next edge. An in-flight response is ignored.
- A stall with a full FIFO stops requests; nothing is dropped.

Optional Feature:
- Macro: IF_MISALIGN_TRAP_EN.
- Defined:
  - Extra output fetch_misaligned_o (1 bit, reset 0).
  - When redirect_pc_i[1:0]!=0 with redirect_i=1, no fetch is issued and a single entry {pc=redirect_pc_i, inst=NOP} is pushed.
  - fetch_misaligned_o=1 while that entry is at the head.
  - Fetching stalls until the next redirect.
- Undefined: the port is absent; redirect_pc_i[1:0] is forced to 0.

Decomposition:
- Shared package / riscv-defines: RISCV_NOP (32'h0000_0013), RISCV_RESET_PC, FSM state encodings IF_ST_REQ/WAIT/DROP.
- One sub-module: if_fifo.
  - Synchronous FIFO, width XLEN+32, depth FIFO_DEPTH.
  - Ports: push, pop, flush, count, full, empty.
  - Clear has priority over push and pop.

Test Plan:
- Reset, gnt=1 every request, rvalid the cycle after the grant, stall=0 → addresses 0x80000000, 0x80000004, 0x80000008…; each pc_o/inst_o pair matches; inst_valid_o rises 2 cycles after the first grant.
- Hold stall_i=1 with FIFO_DEPTH=2 → exactly 2 requests granted, then imem_req_o=0. Release stall → head popped, next request the following cycle, no instruction lost or duplicated.
- Redirect to 0x80001000 while in WAIT, rvalid 3 cycles later → that data is dropped; next request addr=0x80001000; FIFO empty after the flush.
- Redirect in the same cycle as rvalid → data discarded, no DROP state, next request to the new PC.
- Hold gnt=0 for 5 cycles → imem_req_o stays 1 and imem_addr_o stays stable; fetch_pc advances only on the grant.
- (IF_MISALIGN_TRAP_EN) Redirect to 0x80000002 → no imem_req_o; inst_valid_o=1, inst_o=NOP, pc_o=0x80000002, fetch_misaligned_o=1.

Source files
------------

// File: rtl/if_stage_pkg.sv
// Shared RISC-V fetch definitions: NOP encoding, reset PC and fetch FSM states.
package if_stage_pkg;

   localparam logic [31:0] RISCV_NOP      = 32'h0000_0013;
   localparam logic [63:0] RISCV_RESET_PC = 64'h0000_0000_8000_0000;

   typedef enum logic [1:0] {
      IF_ST_REQ  = 2'd0,
      IF_ST_WAIT = 2'd1,
      IF_ST_DROP = 2'd2
   } if_state_e;

endpackage

// File: rtl/if_stage_fifo.sv
// Register-based synchronous fetch buffer; flush wins over push and pop.
module if_fifo #(
   parameter int W     = 96,
   parameter int DEPTH = 2,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          flush_i,
   input  logic          push_i,
   input  logic [W-1:0]  data_i,
   input  logic          pop_i,
   output logic [W-1:0]  data_o,
   output logic [AW:0]   count_o,
   output logic          full_o,
   output logic          empty_o
);

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] rd_ptr_q, wr_ptr_q;
   logic [AW:0]   count_q;
   logic          push_ok, pop_ok;

   assign full_o  = (count_q == (AW+1)'(DEPTH));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign data_o  = mem_q[rd_ptr_q];

   // A push into a full buffer is legal only when the head leaves in the same cycle.
   assign pop_ok  = pop_i & ~empty_o;
   assign push_ok = push_i & (~full_o | pop_ok);

   always_ff @(posedge clk) begin
      if (rst || flush_i) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
         count_q <= count_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok && !flush_i && !rst) mem_q[wr_ptr_q] <= data_i;
   end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: single-outstanding imem handshake feeding a small buffer to decode.
// Optional misaligned-redirect trap is enabled by defining IF_MISALIGN_TRAP_EN.
//
// state      | meaning
// IF_ST_REQ  | free to issue a request when the buffer has room
// IF_ST_WAIT | one live request outstanding
// IF_ST_DROP | one stale request outstanding, its response is discarded
module if_stage
   import if_stage_pkg::*;
#(
   parameter int               XLEN       = 64,
   parameter logic [XLEN-1:0]  RESET_PC   = XLEN'(RISCV_RESET_PC),
   parameter int               FIFO_DEPTH = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             stall_i,
   input  logic             redirect_i,
   input  logic [XLEN-1:0]  redirect_pc_i,
   output logic             imem_req_o,
   output logic [XLEN-1:0]  imem_addr_o,
   input  logic             imem_gnt_i,
   input  logic             imem_rvalid_i,
   input  logic [31:0]      imem_rdata_i,
   output logic             inst_valid_o,
   output logic [31:0]      inst_o,
   output logic [XLEN-1:0]  pc_o
`ifdef IF_MISALIGN_TRAP_EN
   ,
   output logic             fetch_misaligned_o
`endif
);

   localparam int FW = XLEN + 32;
   localparam int AW = $clog2(FIFO_DEPTH);

   if_state_e       state_q;
   logic [XLEN-1:0] fetch_pc_q, pc_lat_q, last_pc_q;
   logic [XLEN-1:0] redir_pc;
   logic            fetch_blocked, outstanding, space;
   logic            fifo_push, fifo_pop, fifo_full, fifo_empty;
   logic [AW:0]     fifo_count;
   logic [FW-1:0]   fifo_din, fifo_dout;
   logic [XLEN-1:0] head_pc, push_pc;
   logic [31:0]     push_inst;

`ifdef IF_MISALIGN_TRAP_EN
   logic trap_q, trap_pend_q, redir_misaligned;

   assign redir_pc           = redirect_pc_i;
   assign redir_misaligned   = |redirect_pc_i[1:0];
   assign fetch_blocked      = trap_q;
   assign fetch_misaligned_o = trap_q & inst_valid_o;
   assign fifo_push = (trap_pend_q | (state_q == IF_ST_WAIT & imem_rvalid_i)) & ~redirect_i & ~rst;
   assign push_pc   = trap_pend_q ? fetch_pc_q : pc_lat_q;
   assign push_inst = trap_pend_q ? RISCV_NOP : imem_rdata_i;

   always_ff @(posedge clk) begin
      if (rst) begin
         trap_q      <= 1'b0;
         trap_pend_q <= 1'b0;
      end else if (redirect_i) begin
         trap_q      <= redir_misaligned;
         trap_pend_q <= redir_misaligned;
      end else begin
         trap_pend_q <= 1'b0;
      end
   end
`else
   logic unused_redir_lsb;

   // Without the trap, fetch addresses are always word aligned.
   assign redir_pc         = {redirect_pc_i[XLEN-1:2], 2'b00};
   assign unused_redir_lsb = ^redirect_pc_i[1:0];
   assign fetch_blocked    = 1'b0;
   assign fifo_push = (state_q == IF_ST_WAIT) & imem_rvalid_i & ~redirect_i & ~rst;
   assign push_pc   = pc_lat_q;
   assign push_inst = imem_rdata_i;
`endif

   assign outstanding = (state_q != IF_ST_REQ);
   assign space       = ~fifo_full & ((int'(fifo_count) + int'(outstanding)) < FIFO_DEPTH);
   assign imem_req_o  = (state_q == IF_ST_REQ) & space & ~redirect_i & ~rst & ~fetch_blocked;
   assign imem_addr_o = fetch_pc_q;

   assign fifo_din = {push_pc, push_inst};
   assign fifo_pop = inst_valid_o & ~stall_i & ~redirect_i;
   assign head_pc  = fifo_dout[FW-1:32];

   assign inst_valid_o = ~fifo_empty;
   assign inst_o       = fifo_empty ? RISCV_NOP : fifo_dout[31:0];
   assign pc_o         = fifo_empty ? last_pc_q : head_pc;

   if_fifo #(
      .W     (FW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .flush_i (redirect_i),
      .push_i  (fifo_push),
      .data_i  (fifo_din),
      .pop_i   (fifo_pop),
      .data_o  (fifo_dout),
      .count_o (fifo_count),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IF_ST_REQ;
         fetch_pc_q <= RESET_PC;
         pc_lat_q   <= '0;
         last_pc_q  <= '0;
      end else begin
         if (inst_valid_o) last_pc_q <= head_pc;
         if (redirect_i) begin
            fetch_pc_q <= redir_pc;
            // A request still in flight must have its response swallowed.
            case (state_q)
               IF_ST_WAIT,
               IF_ST_DROP: state_q <= imem_rvalid_i ? IF_ST_REQ : IF_ST_DROP;
               default:    state_q <= IF_ST_REQ;
            endcase
         end else begin
            case (state_q)
               IF_ST_REQ: begin
                  if (imem_req_o && imem_gnt_i) begin
                     state_q    <= IF_ST_WAIT;
                     pc_lat_q   <= fetch_pc_q;
                     fetch_pc_q <= fetch_pc_q + XLEN'(4);
                  end
               end
               IF_ST_WAIT,
               IF_ST_DROP: if (imem_rvalid_i) state_q <= IF_ST_REQ;
               default:    state_q <= IF_ST_REQ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_if_stage.sv
// Directed self-checking bench for if_stage (build with IF_MISALIGN_TRAP_EN to cover the trap).
module tb_if_stage;

   localparam logic [63:0] RST_PC = 64'h0000_0000_8000_0000;
   localparam logic [31:0] NOP    = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst, stall, redirect, gnt, rvalid;
   logic [63:0] redirect_pc;
   logic [31:0] rdata;
   logic        req, valid;
   logic [63:0] addr, pc;
   logic [31:0] inst;
`ifdef IF_MISALIGN_TRAP_EN
   logic        misaligned;
`endif

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   if_stage dut (
      .clk           (clk),
      .rst           (rst),
      .stall_i       (stall),
      .redirect_i    (redirect),
      .redirect_pc_i (redirect_pc),
      .imem_req_o    (req),
      .imem_addr_o   (addr),
      .imem_gnt_i    (gnt),
      .imem_rvalid_i (rvalid),
      .imem_rdata_i  (rdata),
      .inst_valid_o  (valid),
      .inst_o        (inst),
      .pc_o          (pc)
`ifdef IF_MISALIGN_TRAP_EN
      ,
      .fetch_misaligned_o (misaligned)
`endif
   );

   function automatic logic [31:0] word_of(input logic [63:0] a);
      return a[31:0] ^ 32'h1234_5000;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
      gnt = 1'b0; rvalid = 1'b0; rdata = '0;
      tick();
      tick();
      rst = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
      gnt = 1'b0; rvalid = 1'b0; rdata = '0;
      tick();
      tick();
      total++; if (req !== 1'b0) begin bad++; $display("FAIL reset_req got=%0b exp=0", req); end
      total++; if (addr !== RST_PC) begin bad++; $display("FAIL reset_addr got=%h exp=%h", addr, RST_PC); end
      total++; if (valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b exp=0", valid); end
      total++; if (inst !== NOP) begin bad++; $display("FAIL reset_inst got=%h exp=%h", inst, NOP); end
      total++; if (pc !== 64'h0) begin bad++; $display("FAIL reset_pc got=%h exp=0", pc); end
`ifdef IF_MISALIGN_TRAP_EN
      total++; if (misaligned !== 1'b0) begin bad++; $display("FAIL reset_misaligned got=%0b exp=0", misaligned); end
`endif
      rst = 1'b0;
      #1;
      total++; if (req !== 1'b1) begin bad++; $display("FAIL post_reset_req got=%0b exp=1", req); end
   endtask

   task automatic test_stream();
      logic [63:0] a;
      do_reset();
      for (int i = 0; i < 4; i++) begin
         a = RST_PC + 64'(4 * i);
         gnt = 1'b1;
         total++; if (req !== 1'b1 || addr !== a) begin bad++; $display("FAIL stream_req[%0d] req=%0b addr=%h exp addr=%h", i, req, addr, a); end
         tick();
         gnt = 1'b0; rvalid = 1'b1; rdata = word_of(a);
         #1;
         total++; if (req !== 1'b0 || valid !== 1'b0) begin bad++; $display("FAIL stream_rvalid_cycle[%0d] req=%0b valid=%0b exp 0/0", i, req, valid); end
         tick();
         rvalid = 1'b0;
         #1;
         total++; if (valid !== 1'b1 || pc !== a || inst !== word_of(a)) begin bad++; $display("FAIL stream_out[%0d] valid=%0b pc=%h inst=%h exp pc=%h inst=%h", i, valid, pc, inst, a, word_of(a)); end
      end
      gnt = 1'b0;
      tick();
      total++; if (valid !== 1'b0 || inst !== NOP || pc !== RST_PC + 64'd12) begin bad++; $display("FAIL stream_drain valid=%0b inst=%h pc=%h", valid, inst, pc); end
   endtask

   task automatic test_stall_full();
      int          grants;
      logic        pend, next_pend;
      logic [63:0] pend_addr, next_addr;
      do_reset();
      stall = 1'b1; grants = 0; pend = 1'b0; pend_addr = '0; next_addr = '0;
      for (int c = 0; c < 8; c++) begin
         rvalid = pend; rdata = word_of(pend_addr); gnt = 1'b1;
         #1;
         next_pend = req;
         if (req) begin grants++; next_addr = addr; end
         tick();
         pend = next_pend; pend_addr = next_addr;
      end
      gnt = 1'b0; rvalid = 1'b0;
      #1;
      total++; if (grants !== 2) begin bad++; $display("FAIL stall_grants got=%0d exp=2", grants); end
      total++; if (req !== 1'b0) begin bad++; $display("FAIL stall_req got=%0b exp=0", req); end
      total++; if (valid !== 1'b1 || pc !== RST_PC || inst !== word_of(RST_PC)) begin bad++; $display("FAIL stall_head valid=%0b pc=%h inst=%h", valid, pc, inst); end
      stall = 1'b0;
      tick();
      total++; if (req !== 1'b1 || pc !== RST_PC + 64'd4 || inst !== word_of(RST_PC + 64'd4)) begin bad++; $display("FAIL stall_release req=%0b pc=%h inst=%h", req, pc, inst); end
      gnt = 1'b1;
      tick();
      gnt = 1'b0; rvalid = 1'b1; rdata = word_of(RST_PC + 64'd8);
      #1;
      total++; if (valid !== 1'b0) begin bad++; $display("FAIL stall_no_dup valid=%0b exp=0", valid); end
      tick();
      rvalid = 1'b0;
      #1;
      total++; if (valid !== 1'b1 || pc !== RST_PC + 64'd8) begin bad++; $display("FAIL stall_third valid=%0b pc=%h exp=%h", valid, pc, RST_PC + 64'd8); end
   endtask

   task automatic test_redirect_wait();
      localparam logic [63:0] TGT = 64'h0000_0000_8000_1000;
      do_reset();
      stall = 1'b1; gnt = 1'b1;
      tick();
      gnt = 1'b0; rvalid = 1'b1; rdata = word_of(RST_PC);
      tick();
      rvalid = 1'b0; gnt = 1'b1;
      tick();
      gnt = 1'b0;
      #1;
      total++; if (valid !== 1'b1 || pc !== RST_PC) begin bad++; $display("FAIL redir_pre valid=%0b pc=%h", valid, pc); end
      redirect = 1'b1; redirect_pc = TGT;
      #1;
      total++; if (req !== 1'b0) begin bad++; $display("FAIL redir_req_mask got=%0b exp=0", req); end
      tick();
      redirect = 1'b0;
      #1;
      total++; if (valid !== 1'b0 || inst !== NOP || pc !== RST_PC) begin bad++; $display("FAIL redir_flush valid=%0b inst=%h pc=%h", valid, inst, pc); end
      total++; if (req !== 1'b0 || addr !== TGT) begin bad++; $display("FAIL redir_drop req=%0b addr=%h exp addr=%h", req, addr, TGT); end
      tick();
      tick();
      rvalid = 1'b1; rdata = 32'hDEAD_BEEF;
      #1;
      total++; if (req !== 1'b0) begin bad++; $display("FAIL redir_stale_req got=%0b exp=0", req); end
      tick();
      rvalid = 1'b0;
      #1;
      total++; if (valid !== 1'b0 || req !== 1'b1 || addr !== TGT) begin bad++; $display("FAIL redir_after_drop valid=%0b req=%0b addr=%h", valid, req, addr); end
      stall = 1'b0; gnt = 1'b1;
      tick();
      gnt = 1'b0; rvalid = 1'b1; rdata = word_of(TGT);
      tick();
      rvalid = 1'b0;
      #1;
      total++; if (valid !== 1'b1 || pc !== TGT || inst !== word_of(TGT)) begin bad++; $display("FAIL redir_new_fetch valid=%0b pc=%h inst=%h", valid, pc, inst); end
   endtask

   task automatic test_redirect_rvalid();
      localparam logic [63:0] TGT = 64'h0000_0000_8000_2000;
      do_reset();
      gnt = 1'b1;
      tick();
      gnt = 1'b0; rvalid = 1'b1; rdata = 32'hBAD0_0001; redirect = 1'b1; redirect_pc = TGT;
      #1;
      total++; if (req !== 1'b0) begin bad++; $display("FAIL redir_rv_req got=%0b exp=0", req); end
      tick();
      rvalid = 1'b0; redirect = 1'b0;
      #1;
      total++; if (valid !== 1'b0 || req !== 1'b1 || addr !== TGT || pc !== 64'h0) begin bad++; $display("FAIL redir_rv valid=%0b req=%0b addr=%h pc=%h", valid, req, addr, pc); end
   endtask

   task automatic test_gnt_hold();
      do_reset();
      for (int i = 0; i < 5; i++) begin
         total++; if (req !== 1'b1 || addr !== RST_PC) begin bad++; $display("FAIL gnt_hold[%0d] req=%0b addr=%h", i, req, addr); end
         tick();
      end
      gnt = 1'b1;
      tick();
      gnt = 1'b0;
      #1;
      total++; if (req !== 1'b0 || addr !== RST_PC + 64'd4) begin bad++; $display("FAIL gnt_hold_adv req=%0b addr=%h", req, addr); end
      rvalid = 1'b1; rdata = word_of(RST_PC);
      tick();
      rvalid = 1'b0;
      #1;
      total++; if (valid !== 1'b1 || pc !== RST_PC) begin bad++; $display("FAIL gnt_hold_data valid=%0b pc=%h", valid, pc); end
   endtask

   task automatic test_stale_and_reset();
      do_reset();
      rvalid = 1'b1; rdata = 32'hFFFF_FFFF;
      tick();
      rvalid = 1'b0;
      #1;
      total++; if (valid !== 1'b0 || req !== 1'b1) begin bad++; $display("FAIL stale_in_req valid=%0b req=%0b", valid, req); end
      gnt = 1'b1;
      tick();
      gnt = 1'b0; rst = 1'b1; rvalid = 1'b1; rdata = 32'h1111_2222;
      #1;
      total++; if (req !== 1'b0) begin bad++; $display("FAIL midreset_req got=%0b exp=0", req); end
      tick();
      rst = 1'b0; rvalid = 1'b0;
      #1;
      total++; if (valid !== 1'b0 || req !== 1'b1 || addr !== RST_PC) begin bad++; $display("FAIL midreset valid=%0b req=%0b addr=%h", valid, req, addr); end
   endtask

   task automatic test_wrap();
      localparam logic [63:0] TOP = 64'hFFFF_FFFF_FFFF_FFFC;
      do_reset();
      redirect = 1'b1; redirect_pc = TOP;
      tick();
      redirect = 1'b0;
      #1;
      total++; if (req !== 1'b1 || addr !== TOP) begin bad++; $display("FAIL wrap_req req=%0b addr=%h", req, addr); end
      gnt = 1'b1;
      tick();
      gnt = 1'b0; rvalid = 1'b1; rdata = 32'h0000_0073;
      #1;
      total++; if (addr !== 64'h0) begin bad++; $display("FAIL wrap_addr got=%h exp=0", addr); end
      tick();
      rvalid = 1'b0;
      #1;
      total++; if (valid !== 1'b1 || pc !== TOP || inst !== 32'h0000_0073) begin bad++; $display("FAIL wrap_out valid=%0b pc=%h inst=%h", valid, pc, inst); end
   endtask

`ifdef IF_MISALIGN_TRAP_EN
   task automatic test_misalign();
      do_reset();
      redirect = 1'b1; redirect_pc = 64'h0000_0000_8000_0002;
      tick();
      redirect = 1'b0;
      #1;
      total++; if (req !== 1'b0) begin bad++; $display("FAIL mis_req got=%0b exp=0", req); end
      tick();
      total++; if (valid !== 1'b1 || inst !== NOP || pc !== 64'h0000_0000_8000_0002 || misaligned !== 1'b1) begin bad++; $display("FAIL mis_entry valid=%0b inst=%h pc=%h mis=%0b", valid, inst, pc, misaligned); end
      total++; if (req !== 1'b0) begin bad++; $display("FAIL mis_req_hold got=%0b exp=0", req); end
      tick();
      total++; if (valid !== 1'b0 || misaligned !== 1'b0 || req !== 1'b0) begin bad++; $display("FAIL mis_after valid=%0b mis=%0b req=%0b", valid, misaligned, req); end
      redirect = 1'b1; redirect_pc = 64'h0000_0000_8000_0100;
      tick();
      redirect = 1'b0;
      #1;
      total++; if (req !== 1'b1 || addr !== 64'h0000_0000_8000_0100) begin bad++; $display("FAIL mis_recover req=%0b addr=%h", req, addr); end
   endtask
`else
   task automatic test_lsb_forced();
      do_reset();
      redirect = 1'b1; redirect_pc = 64'h0000_0000_8000_0006;
      tick();
      redirect = 1'b0;
      #1;
      total++; if (req !== 1'b1 || addr !== 64'h0000_0000_8000_0004) begin bad++; $display("FAIL lsb_forced req=%0b addr=%h exp=80000004", req, addr); end
   endtask
`endif

   initial begin
      #500000;
      $display("FAIL watchdog time limit");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_stream();
      test_stall_full();
      test_redirect_wait();
      test_redirect_rvalid();
      test_gnt_hold();
      test_stale_and_reset();
      test_wrap();
`ifdef IF_MISALIGN_TRAP_EN
      test_misalign();
`else
      test_lsb_forced();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
